// File: rtl/stat_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stat_display_pkg
// Description : Shared types and constants for the statistics display:
//               conversion FSM states, source select codes, segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package stat_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_sel_total    = 3'd0;
    localparam logic [2:0] c_sel_uncond   = 3'd1;
    localparam logic [2:0] c_sel_cond     = 3'd2;
    localparam logic [2:0] c_sel_cond_suc = 3'd3;
    localparam logic [2:0] c_sel_syscall  = 3'd4;

    // Active-low g..a patterns for 0-F; the dp bit is added by the caller.
    localparam logic [6:0] c_seg_patterns [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [39:0] bcd_add3(input logic [39:0] bcd);
        logic [39:0] result;
        result = bcd;
        for (int i = 0; i < 10; i++) begin
            if (result[i*4 +: 4] >= 4'd5)
                result[i*4 +: 4] = result[i*4 +: 4] + 4'd3;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stat_display_seg7.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational nibble to active-low seven-segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import stat_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = c_seg_patterns[nibble];

endmodule
`default_nettype wire

// File: rtl/stat_display.sv
`default_nettype none
// ============================================================================
// Module      : stat_display
// Description : Free-running binary/BCD conversion of a selected statistic
//               and multiplexed 8-digit seven-segment scan.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_display
    import stat_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] SyscallOut,
    input  logic [2:0]  sel,
    input  logic        hex_mode,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy
);

    localparam int unsigned c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_busy;
    logic [31:0]            w_src;
    logic [31:0]            r_bin;
    logic [39:0]            r_bcd;
    logic [39:0]            w_bcd_adj;
    logic                   r_hex;
    logic [4:0]             r_shift_cnt;
    logic [31:0]            r_display;
    logic                   r_ovf;
    logic [c_presc_w-1:0]   r_presc;
    logic [2:0]             r_index;
    logic [3:0]             w_nibble;
    logic [6:0]             w_seg_pat;
    logic [7:0]             r_seg;
    logic [7:0]             r_an;

    always_comb begin
        w_src = '0;
        case (sel)
            c_sel_total:    w_src = total_cycles;
            c_sel_uncond:   w_src = uncondi_num;
            c_sel_cond:     w_src = condi_num;
            c_sel_cond_suc: w_src = condi_suc_num;
            c_sel_syscall:  w_src = SyscallOut;
            default:        w_src = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy       = 1'b0;
                w_next_state = ST_LOAD;
            end
            ST_LOAD:  w_next_state = hex_mode ? ST_DONE : ST_SHIFT;
            ST_SHIFT: w_next_state = (r_shift_cnt == 5'd31) ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign busy      = w_busy;
    assign w_bcd_adj = bcd_add3(r_bcd);

    // Display register only changes in DONE, so a half-shifted value is never shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_hex       <= 1'b0;
            r_shift_cnt <= '0;
            r_display   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_bin       <= w_src;
                    r_hex       <= hex_mode;
                    r_bcd       <= '0;
                    r_shift_cnt <= '0;
                end
                ST_SHIFT: begin
                    r_bcd       <= (w_bcd_adj << 1) | {39'd0, r_bin[31]};
                    r_bin       <= {r_bin[30:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 5'd1;
                end
                ST_DONE: begin
                    if (r_hex) begin
                        r_display <= r_bin;
                        r_ovf     <= 1'b0;
                    end else begin
                        r_display <= r_bcd[31:0];
                        r_ovf     <= |r_bcd[39:32];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_nibble = r_display[{r_index, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .nibble   (w_nibble),
        .segments (w_seg_pat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_index <= '0;
            r_seg   <= 8'hC0;
            r_an    <= 8'hFE;
        end else begin
            if (r_presc == c_presc_max) begin
                r_presc <= '0;
                r_index <= r_index + 3'd1;
            end else begin
                r_presc <= r_presc + c_presc_one;
            end
            r_an  <= ~(8'b1 << r_index);
            r_seg <= {~r_ovf, w_seg_pat};
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_stat_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_stat_display
// Description : Self-checking bench for stat_display (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stat_display;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut;
    logic [2:0]  sel;
    logic        hex_mode;
    logic [7:0]  seg, an;
    logic        busy;

    always #5 clk = ~clk;

    stat_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .total_cycles  (total_cycles),
        .uncondi_num   (uncondi_num),
        .condi_num     (condi_num),
        .condi_suc_num (condi_suc_num),
        .SyscallOut    (SyscallOut),
        .sel           (sel),
        .hex_mode      (hex_mode),
        .seg           (seg),
        .an            (an),
        .busy          (busy)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        hex;
        logic [31:0] disp;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } obs_t;

    vec_t vecs [9];
    obs_t sb_q [$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Returns at the first negedge of a fresh IDLE cycle (busy rose then fell).
    task automatic wait_next_idle(input string name, output int cycles);
        bit seen_high;
        seen_high = 0;
        cycles    = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (busy === 1'b1) seen_high = 1;
            else if (seen_high && busy === 1'b0) return;
        end
        timeout(name);
    endtask

    // Checks whichever digit is being scanned for 8 consecutive cycles.
    task automatic check_live(input string name, input logic [31:0] disp, input logic ovf);
        int idx;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < 8; i++)
                if (an === ~(8'b1 << i)) idx = i;
            if (idx < 0) begin
                check($sformatf("%s_an", name), {8'h00, an}, 16'h00FE);
            end else begin
                check($sformatf("%s_d%0d", name, idx), {8'h00, seg},
                      {8'h00, ~ovf, pat(disp[idx*4 +: 4])});
            end
        end
    endtask

    initial begin
        int   cyc;
        obs_t exp_o;
        bit   found;

        vecs[0] = '{3'd0, 1'b0, 32'h12345678, 1'b0};
        vecs[1] = '{3'd4, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{3'd2, 1'b0, 32'h94967295, 1'b1};
        vecs[3] = '{3'd3, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{3'd1, 1'b0, 32'h99999999, 1'b0};
        vecs[5] = '{3'd5, 1'b0, 32'h00000000, 1'b0};
        vecs[6] = '{3'd7, 1'b1, 32'h00000000, 1'b0};
        vecs[7] = '{3'd0, 1'b1, 32'h00BC614E, 1'b0};
        vecs[8] = '{3'd4, 1'b0, 32'h35928559, 1'b1};

        rst           = 1'b0;
        total_cycles  = 32'd12345678;
        uncondi_num   = 32'd99999999;
        condi_num     = 32'hFFFFFFFF;
        condi_suc_num = 32'd100000000;
        SyscallOut    = 32'hDEADBEEF;
        sel           = 3'd0;
        hex_mode      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_seg",  {8'h00, seg},  16'h00C0);
        check("reset_an",   {8'h00, an},   16'h00FE);
        check("reset_busy", {15'h0, busy}, 16'h0000);
        rst = 1'b1;

        foreach (vecs[v]) begin
            sel      = vecs[v].sel;
            hex_mode = vecs[v].hex;
            repeat (80) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                exp_o.an  = ~(8'b1 << k);
                exp_o.seg = {~vecs[v].ovf, pat(vecs[v].disp[k*4 +: 4])};
                sb_q.push_back(exp_o);
            end
            found = 0;
            for (int t = 0; t < 40 && !found; t++) begin
                if (an === 8'hFE) found = 1;
                else @(negedge clk);
            end
            if (!found) begin
                timeout($sformatf("v%0d_sync", v));
                sb_q.delete();
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) repeat (SCAN_DIV) @(negedge clk);
                    exp_o = sb_q.pop_front();
                    check($sformatf("v%0d_digit%0d", v, k), {an, seg}, {exp_o.an, exp_o.seg});
                end
                repeat (SCAN_DIV) @(negedge clk);
                check($sformatf("v%0d_wrap", v), {8'h00, an}, 16'h00FE);
            end
        end

        // Conversion periods
        sel = 3'd4; hex_mode = 1'b1;
        repeat (10) @(negedge clk);
        wait_next_idle("hex_sync", cyc);
        wait_next_idle("hex_period", cyc);
        check("hex_period", 16'(cyc), 16'd3);
        sel = 3'd0; hex_mode = 1'b0;
        repeat (80) @(negedge clk);
        wait_next_idle("dec_sync", cyc);
        wait_next_idle("dec_period", cyc);
        check("dec_period", 16'(cyc), 16'd35);

        // Select change mid-SHIFT: old value shown first, new value one conversion later
        repeat (10) @(negedge clk);
        sel = 3'd1;
        wait_next_idle("midsel_done", cyc);
        check_live("midsel_old", 32'h12345678, 1'b0);
        wait_next_idle("midsel_next", cyc);
        check_live("midsel_new", 32'h99999999, 1'b0);

        // Reset mid-conversion abandons it; restart runs a full 35-cycle conversion
        sel = 3'd0;
        wait_next_idle("rstmid_sync", cyc);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rstmid_seg",  {8'h00, seg},  16'h00C0);
        check("rstmid_an",   {8'h00, an},   16'h00FE);
        check("rstmid_busy", {15'h0, busy}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        wait_next_idle("rstmid_period", cyc);
        check("rstmid_period", 16'(cyc), 16'd35);
        check_live("rstmid_value", 32'h12345678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stat_display.md
STAT_DISPLAY -- requirements
Module: stat_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per display digit.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 total_cycles  input  32  cycle counter from the statistics block.
REQ-005 uncondi_num  input  32  unconditional-branch count.
REQ-006 condi_num  input  32  conditional-branch count.
REQ-007 condi_suc_num  input  32  taken-conditional-branch count.
REQ-008 SyscallOut  input  32  last syscall display value.
REQ-009 sel  input  3  source select: 0 total_cycles, 1 uncondi_num, 2 condi_num, 3 condi_suc_num, 4 SyscallOut, 5-7 constant 0.
REQ-010 hex_mode  input  1  1 = hexadecimal digits, 0 = decimal digits.
REQ-011 seg  output  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.
REQ-012 an  output  8  active-low digit enables; an[0] = rightmost digit.
REQ-013 busy  output  1  high while a conversion is in progress.

Function
REQ-014 The conversion FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-015 Transitions SHALL be: IDLE->LOAD always; LOAD->SHIFT if the latched hex_mode = 0, else LOAD->DONE; SHIFT->DONE after exactly 32 SHIFT cycles; DONE->IDLE.
REQ-016 In LOAD, the block SHALL latch the selected 32-bit value and hex_mode; later changes to sel or hex_mode SHALL NOT affect the current conversion.
REQ-017 Decimal mode SHALL use sequential double-dabble: 1 bit per SHIFT cycle, with add-3 applied to every BCD nibble >= 5 before each shift, over a 40-bit (10-digit) BCD register.
REQ-018 Decimal period SHALL be 35 cycles (IDLE, LOAD, 32 SHIFT, DONE).
REQ-019 Hex period SHALL be 3 cycles (IDLE, LOAD, DONE).
REQ-020 Conversion SHALL be free-running: a new conversion starts in the IDLE cycle after every DONE.
REQ-021 The 8-digit display register SHALL update only in DONE, so the display never shows a partially converted value.
REQ-022 Hex mode SHALL load display digit i with nibble i of the value; the overflow flag SHALL be 0.
REQ-023 Decimal mode SHALL load the lower 8 BCD digits; the overflow flag SHALL be set when BCD digit 8 or 9 is nonzero (value > 99,999,999).
REQ-024 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-025 A prescaler SHALL count 0..SCAN_DIV-1; on wrap, the 3-bit digit index SHALL increment, wrapping 7->0.
REQ-026 Anode decode SHALL drive an = ~(8'b1 << index).
REQ-027 seg[6:0] SHALL be the decoded pattern of display digit[index]: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (bit 7 excluded).
REQ-028 seg[7] SHALL be 0 (dp lit) on every digit when the overflow flag is 1, and 1 otherwise.
REQ-029 seg and an SHALL be registered outputs with one cycle of latency from the index and display register.

Reset
REQ-030 While rst is low, the block SHALL hold: FSM = IDLE, prescaler = 0, index = 0, display register = 0, overflow = 0, seg = 8'hC0, an = 8'hFE, busy = 0.
REQ-031 Reset asserted mid-conversion SHALL abandon the conversion; the first conversion after release SHALL restart from IDLE.

Structure
REQ-032 Package stat_display_pkg SHALL hold the FSM state enum, the sel codes, and the 16-entry seven-segment pattern constants.
REQ-033 The nibble-to-segment decode SHALL be a combinational sub-module named seg7_decode.

Verification
REQ-034 Reset: rst = 0 -> seg = 8'hC0, an = 8'hFE, busy = 0.
REQ-035 Decimal: sel = 0, total_cycles = 12345678, hex_mode = 0 -> within 35 cycles digits 7..0 = 1..8; digit 0 seg = 8'h80; no dp.
REQ-036 Hex: sel = 4, SyscallOut = 32'hDEADBEEF, hex_mode = 1 -> within 3 cycles digit 7 seg = 8'hA1 and digit 0 seg = 8'h8E.
REQ-037 Overflow: sel = 2, condi_num = 32'hFFFFFFFF, decimal -> digits show 94967295 with seg[7] = 0 on all digits.
REQ-038 Mid-conversion select change: sel 0->1 during SHIFT -> the old value is displayed at DONE; the new value is displayed one conversion later.
REQ-039 Scan: SCAN_DIV = 4 -> an steps FE, FD, FB, ..., 7F, FE, changing every 4 cycles.
